// File: rtl/csa_pipe_add.sv
// rtl/csa_pipe_add.sv - two-stage pipelined carry-select adder/subtractor with valid/ready
//
// Purpose:
//   Streams operand beats through a carry-select adder split into two
//   registered stages. Stage 1 ripple-adds segment 0 with the effective
//   carry-in and precomputes both carry-in candidates for every upper
//   segment. Stage 2 walks the select chain and forms sum/cout/ovf.
//   The pipeline is elastic: one beat per cycle while out_ready is high,
//   two beats of buffering under backpressure.
//
// Parameters:
//   WIDTH  operand/result width, must be a multiple of SEG
//   SEG    carry-select segment width, SEG >= 2
//
// Ports:
//   clk        clock, all state on rising edge
//   rst        asynchronous active-high reset
//   in_valid   operand beat valid
//   in_ready   block can accept a beat (combinational)
//   a, b       operands
//   cin        carry-in (ignored when sub=1)
//   sub        0: a+b+cin, 1: a-b
//   out_valid  result beat valid
//   out_ready  consumer accepts result
//   sum        result
//   cout       carry out of MSB (subtract: 1 = no borrow)
//   ovf        signed two's-complement overflow
//
// Configuration:
//   CSA_PIPE_SAT_EN  when defined, sum saturates on signed overflow;
//                    ovf and cout are reported unmodified.

module csa_pipe_add #(
  parameter int WIDTH = 16,
  parameter int SEG   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSEG  = WIDTH / SEG;
  // Candidate slot j holds segment j+1; keep at least one slot so the
  // declarations stay legal when WIDTH == SEG.
  localparam int NCAND = (NSEG > 1) ? NSEG - 1 : 1;

  generate
    if ((WIDTH % SEG) != 0 || SEG < 2) begin : g_bad_cfg
      $error("csa_pipe_add: WIDTH must be a multiple of SEG and SEG >= 2");
    end
  endgenerate

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  logic v1, v2;
  logic advance2;
  logic accept;

  assign advance2  = v1 && (!v2 || out_ready);
  assign in_ready  = !v1 || advance2;
  assign accept    = in_valid && in_ready;
  assign out_valid = v2;

  // ---------------------------------------------------------------------
  // Stage 1 combinational: effective operands and segment candidates
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0]            bx;
  logic                        c0;
  logic [SEG-1:0]              seg0_sum_d;
  logic                        seg0_co_d;
  logic [NCAND-1:0][SEG-1:0]   cs0_d, cs1_d;
  logic [NCAND-1:0]            cc0_d, cc1_d;

  // Subtraction is a + ~b + 1, so the forced carry-in replaces cin.
  assign bx = sub ? ~b : b;
  assign c0 = sub ? 1'b1 : cin;

  always_comb begin
    {seg0_co_d, seg0_sum_d} = {1'b0, a[SEG-1:0]} + {1'b0, bx[SEG-1:0]}
                              + {{SEG{1'b0}}, c0};
    cs0_d = '0;
    cs1_d = '0;
    cc0_d = '0;
    cc1_d = '0;
    for (int j = 0; j < NSEG - 1; j++) begin
      {cc0_d[j], cs0_d[j]} = {1'b0, a[(j+1)*SEG +: SEG]}
                             + {1'b0, bx[(j+1)*SEG +: SEG]};
      {cc1_d[j], cs1_d[j]} = {1'b0, a[(j+1)*SEG +: SEG]}
                             + {1'b0, bx[(j+1)*SEG +: SEG]}
                             + (SEG+1)'(1);
    end
  end

  // ---------------------------------------------------------------------
  // Stage 1 registers
  // ---------------------------------------------------------------------
  logic [SEG-1:0]              seg0_sum_q;
  logic                        seg0_co_q;
  logic [NCAND-1:0][SEG-1:0]   cs0_q, cs1_q;
  logic [NCAND-1:0]            cc0_q, cc1_q;
  logic                        a_msb_q, bx_msb_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v1         <= 1'b0;
      seg0_sum_q <= '0;
      seg0_co_q  <= 1'b0;
      cs0_q      <= '0;
      cs1_q      <= '0;
      cc0_q      <= '0;
      cc1_q      <= '0;
      a_msb_q    <= 1'b0;
      bx_msb_q   <= 1'b0;
    end else begin
      // A new accept wins over a drain, so simultaneous accept and
      // advance2 simply overwrite stage 1 with the next beat.
      if (accept) begin
        v1         <= 1'b1;
        seg0_sum_q <= seg0_sum_d;
        seg0_co_q  <= seg0_co_d;
        cs0_q      <= cs0_d;
        cs1_q      <= cs1_d;
        cc0_q      <= cc0_d;
        cc1_q      <= cc1_d;
        a_msb_q    <= a[WIDTH-1];
        bx_msb_q   <= bx[WIDTH-1];
      end else if (advance2) begin
        v1 <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------
  // Stage 2 combinational: resolve the carry-select chain
  // ---------------------------------------------------------------------
  logic [WIDTH-1:0] raw_sum;
  logic [WIDTH-1:0] res_sum;
  logic             raw_cout;
  logic             raw_ovf;
  logic             carry;

  always_comb begin
    raw_sum          = '0;
    raw_sum[SEG-1:0] = seg0_sum_q;
    carry            = seg0_co_q;
    for (int j = 0; j < NSEG - 1; j++) begin
      raw_sum[(j+1)*SEG +: SEG] = carry ? cs1_q[j] : cs0_q[j];
      carry                     = carry ? cc1_q[j] : cc0_q[j];
    end
    raw_cout = carry;
  end

  // Overflow: like-signed operands producing a result of the other sign.
  assign raw_ovf = (a_msb_q == bx_msb_q) && (raw_sum[WIDTH-1] != a_msb_q);

`ifdef CSA_PIPE_SAT_EN
  // Operand sign tells the overflow direction: positive operands clamp to
  // the largest positive value, negative ones to the most negative.
  always_comb begin
    res_sum = raw_sum;
    if (raw_ovf) begin
      res_sum = a_msb_q ? {1'b1, {(WIDTH-1){1'b0}}}
                        : {1'b0, {(WIDTH-1){1'b1}}};
    end
  end
`else
  assign res_sum = raw_sum;
`endif

  // ---------------------------------------------------------------------
  // Stage 2 registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v2   <= 1'b0;
      sum  <= '0;
      cout <= 1'b0;
      ovf  <= 1'b0;
    end else begin
      if (advance2) begin
        v2   <= 1'b1;
        sum  <= res_sum;
        cout <= raw_cout;
        ovf  <= raw_ovf;
      end else if (out_ready) begin
        v2 <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_csa_pipe_add.sv
// tb/tb_csa_pipe_add.sv - directed self-checking bench for csa_pipe_add

module tb_csa_pipe_add;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] a;
  logic [15:0] b;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int passed = 0;
  int failed = 0;
  int total  = 0;

  csa_pipe_add #(.WIDTH(16), .SEG(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef CSA_PIPE_SAT_EN
  localparam logic [15:0] EXP_POS_OVF = 16'h7FFF;
  localparam logic [15:0] EXP_SUB_OVF = 16'h8000;
  localparam logic [15:0] EXP_NEG_OVF = 16'h8000;
`else
  localparam logic [15:0] EXP_POS_OVF = 16'h8000;
  localparam logic [15:0] EXP_SUB_OVF = 16'h7FFF;
  localparam logic [15:0] EXP_NEG_OVF = 16'h0000;
`endif

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Single beat through an empty pipe: accept at edge k, nothing after k,
  // result visible after edge k+1.
  task automatic run_one(input string tag, input logic [15:0] ta, input logic [15:0] tb,
                         input logic tc, input logic ts, input logic [15:0] es,
                         input logic ec, input logic eo);
    @(negedge clk);
    a = ta; b = tb; cin = tc; sub = ts; in_valid = 1'b1;
    check({tag, "_in_ready"}, in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    a = 16'($urandom); b = 16'($urandom); cin = 1'($urandom); sub = 1'($urandom);
    check({tag, "_lat1_valid"}, out_valid, 0);
    @(negedge clk);
    check({tag, "_valid"}, out_valid, 1);
    check({tag, "_sum"}, sum, es);
    check({tag, "_cout"}, cout, ec);
    check({tag, "_ovf"}, ovf, eo);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_sum", sum, 0);
    check("rst_cout", cout, 0);
    check("rst_ovf", ovf, 0);
    rst = 1'b0;
    #1;
    check("rel_in_ready", in_ready, 1);

    // Directed arithmetic vectors
    run_one("add_ff_1",  16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0);
    run_one("add_carry", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_one("add_povf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, EXP_POS_OVF, 1'b0, 1'b1);
    run_one("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_one("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, EXP_SUB_OVF, 1'b1, 1'b1);
    run_one("add_cin",   16'h1234, 16'h0000, 1'b1, 1'b0, 16'h1235, 1'b0, 1'b0);
    run_one("sub_cin",   16'h0010, 16'h0010, 1'b1, 1'b1, 16'h0000, 1'b1, 1'b0);
    run_one("add_novf",  16'h8000, 16'h8000, 1'b0, 1'b0, EXP_NEG_OVF, 1'b1, 1'b1);

    // Backpressure: two beats fill the pipe, third is held
    @(negedge clk);
    out_ready = 1'b0;
    a = 16'h0001; b = 16'h0001; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    check("bp_rdy1", in_ready, 1);
    @(negedge clk);
    a = 16'h0002; b = 16'h0002;
    check("bp_rdy2", in_ready, 1);
    @(negedge clk);
    a = 16'h0003; b = 16'h0003;
    check("bp_full_rdy", in_ready, 0);
    check("bp_full_valid", out_valid, 1);
    check("bp_full_sum", sum, 16'h0002);
    @(negedge clk);
    check("bp_hold_rdy", in_ready, 0);
    check("bp_hold_sum", sum, 16'h0002);
    out_ready = 1'b1;
    #1;
    check("bp_rel_rdy", in_ready, 1);
    check("bp_out0_sum", sum, 16'h0002);
    @(negedge clk);
    in_valid = 1'b0;
    check("bp_out1_valid", out_valid, 1);
    check("bp_out1_sum", sum, 16'h0004);
    @(negedge clk);
    check("bp_out2_valid", out_valid, 1);
    check("bp_out2_sum", sum, 16'h0006);
    @(negedge clk);
    check("bp_drained", out_valid, 0);

    // Reset mid-stream with both stages full
    out_ready = 1'b0;
    a = 16'h0005; b = 16'h0005; in_valid = 1'b1;
    @(negedge clk);
    a = 16'h0006; b = 16'h0006;
    @(negedge clk);
    in_valid = 1'b0;
    check("mr_full_valid", out_valid, 1);
    check("mr_full_rdy", in_ready, 0);
    #2;
    rst = 1'b1;
    #1;
    check("mr_async_valid", out_valid, 0);
    check("mr_async_sum", sum, 0);
    @(negedge clk);
    rst = 1'b0;
    out_ready = 1'b1;
    #1;
    check("mr_rel_rdy", in_ready, 1);
    @(negedge clk);
    check("mr_post1_valid", out_valid, 0);
    @(negedge clk);
    check("mr_post2_valid", out_valid, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
